hex_display_scan_ctrl: RTL and testbench
========================================

Name: hex_display_scan_ctrl

Overview:
- Avalon-MM slave that owns the board's 4-digit multiplexed 7-segment display; replaces the direct 16-bit hex PIO when digits share one segment bus.
- Sequences digit scanning, hex-to-segment decode, per-digit blanking and decimal points, and global blink.
- Arbitrates the display between software (register writes) and one hardware requester (hw_req/hw_value), which gets a timed override window.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is lit; minimum 2.
- BLINK_DIV, 12500000, clk cycles per blink half-period; minimum 2.
- HOLD_CYCLES, 50000000, clk cycles a hardware override stays on display after the last hw_req.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- hw_req  in  1  hardware override request, sampled each cycle.
- hw_value  in  16  four hex nibbles from the hardware requester.
- seg_n  out  7  segments a..g, active-low, shared by all digits.
- dp_n  out  1  decimal point, active-low.
- dig_en_n  out  4  digit enables, active-low, one-hot-low when lit.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clk is the clock. All registers and counters clear. seg_n=7'h7F, dp_n=1, dig_en_n=4'hF. VALUE=0, CTRL=0 (display disabled), digit index=0, override inactive.
- Register map; writes take effect on the clk edge with chipselect && !write_n:
  - addr0 VALUE: [15:0] stored, upper bits ignored.
  - addr1 CTRL: bit0 enable; bit1 blink_en; [7:4] blank mask (1 = digit dark); [11:8] dp per digit.
  - addr2 STATUS: read-only; bit0 override_active; [3:2] current digit index; writes ignored.
  - addr3: reads 0; writes ignored.
- Reads: readdata is zero-extended, combinational, with 0 wait states. VALUE and CTRL read back exactly as stored.
- Scan: refresh counter counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and the digit index increments 3->0.
  - Digit i shows nibble [4i+3:4i] of the selected source.
  - Outputs are registered and update one cycle after the index changes.
  - All dig_en_n are high for exactly that one update cycle (ghosting guard).
- Source arbitration FSM, two states:
  - SW: shows VALUE. Goes to HW on the cycle hw_req=1. Hold counter loads HOLD_CYCLES-1 and hw_value is latched.
  - HW: shows the latched value. hw_req=1 again re-latches and reloads the counter. The counter decrements each cycle; at 0 with no hw_req, returns to SW.
  - A software VALUE write during HW updates VALUE but does not pre-empt the override.
- Blink: phase toggles every BLINK_DIV cycles. When blink_en=1 and phase=1, dig_en_n=4'hF. Counters keep running.
- When enable=0, dig_en_n=4'hF, seg_n=7'h7F, dp_n=1. Scan, blink and hold counters keep running.
- A blanked digit holds its dig_en_n bit high during its slot.
- Write and hw_req in the same cycle: both take effect; the displayed source follows the FSM (HW).
- Reset mid-scan or mid-override: immediate return to the reset state, outputs dark.

Decomposition:
- Shared package hex_display_pkg holds:
  - register address constants (ADDR_VALUE=0, ADDR_CTRL=1, ADDR_STATUS=2);
  - CTRL bit-position constants;
  - the source-state enum {SRC_SW, SRC_HW};
  - the 16-entry active-low segment lookup constant.
- Sub-module hex_to_seg7: combinational nibble-to-seg_n decoder.
  - Required codes: 0->7'h40, 1->7'h79, 8->7'h00, F->7'h0E, bit order {g,f,e,d,c,b,a}.

Test Plan (REFRESH_DIV=4, BLINK_DIV=64, HOLD_CYCLES=20):
- Reset, then write CTRL=1, VALUE=16'h1234 -> dig_en_n cycles E,D,B,7, each lit 3 cycles after a 1-cycle dark gap. seg_n is decode(4),(3),(2),(1) respectively; read addr0 returns 32'h00001234.
- CTRL=16'h0101 (dp on digit 0, enable) and CTRL=16'h0021 (blank digit 1) -> dp_n=0 only in digit-0 slot; digit-1 slot keeps dig_en_n=4'hF.
- Pulse hw_req one cycle with hw_value=16'hBEEF -> STATUS bit0=1, digits show F,E,E,B. Exactly 20 cycles later STATUS bit0=0 and digits show VALUE. A re-pulse at cycle 10 extends the window to cycle 30.
- CTRL=3 (blink) -> dig_en_n forced 4'hF for 64 cycles, then scanning resumes for 64 cycles, repeating.
- Assert reset_n=0 mid-override and mid-scan -> outputs dark in the same cycle, readdata for addr0/addr1 returns 0, STATUS returns 0.
- Write to addr2/addr3 with 32'hFFFFFFFF -> no state change; addr3 reads 0.

Source files
------------

// File: rtl/hex_display_scan_ctrl_pkg.sv
// hex_display_pkg: shared definitions for the multiplexed 4-digit hex display.
//   - Avalon register addresses and CTRL bit positions
//   - display source arbitration states
//   - active-low 7-segment lookup, bit order {g,f,e,d,c,b,a}
//   - nibble_sel(): picks nibble [4i+3:4i] of a 16-bit value
package hex_display_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  // CTRL layout: bit0 enable, bit1 blink_en, [7:4] blank mask, [11:8] dp
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_BLINK_BIT  = 1;
  localparam int CTRL_BLANK_LSB  = 4;
  localparam int CTRL_DP_LSB     = 8;
  localparam int CTRL_WIDTH      = 12;

  typedef enum logic {
    SRC_SW = 1'b0,
    SRC_HW = 1'b1
  } src_state_e;

  // Active-low segments; a 0 bit lights the segment.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] nibble_sel(input logic [15:0] val, input logic [1:0] idx);
    return val[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/hex_display_scan_ctrl_if.sv
// hex_display_scan_ctrl_if: Avalon-MM slave bus of the hex display controller.
//   address[1:0], chipselect, write_n, writedata[31:0] : master -> slave
//   readdata[31:0]                                      : slave -> master (0 wait states)
interface hex_display_scan_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hex_display_scan_ctrl_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low 7-segment decoder.
//   nibble[3:0] in  : hex digit
//   seg_n[6:0]  out : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table lookup; all 16 codes are defined so no fallback is needed.
  always_comb begin
    seg_n = SEG_LUT[nibble];
  end

endmodule

// File: rtl/hex_display_scan_ctrl.sv
// hex_display_scan_ctrl: Avalon-MM slave driving a 4-digit multiplexed
// 7-segment display, with hardware override window and global blink.
//   clk, reset_n       : clock, asynchronous active-low reset
//   bus (slave)        : address/chipselect/write_n/writedata/readdata
//   hw_req, hw_value   : hardware override request and its four nibbles
//   seg_n, dp_n        : shared active-low segment and decimal-point lines
//   dig_en_n           : active-low digit enables, one-hot-low when lit
module hex_display_scan_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 12500000,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  hex_display_scan_ctrl_if.slave    bus,
  input  logic                      hw_req,
  input  logic [15:0]               hw_value,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic [3:0]                dig_en_n
);

  localparam int REFRESH_W = $clog2(REFRESH_DIV);
  localparam int BLINK_W   = $clog2(BLINK_DIV);
  localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);

  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD    = HOLD_W'(HOLD_CYCLES - 1);

  logic [15:0]            value_r;
  logic [CTRL_WIDTH-1:0]  ctrl_r;
  logic [REFRESH_W-1:0]   refresh_cnt_r;
  logic [1:0]             digit_idx_r;
  logic [BLINK_W-1:0]     blink_cnt_r;
  logic                   blink_phase_r;
  src_state_e             src_r;
  logic [HOLD_W-1:0]      hold_r;
  logic [15:0]            latched_r;

  logic                   wr_s;
  logic                   refresh_tc_s;
  logic [15:0]            shown_s;
  logic [3:0]             nibble_s;
  logic [6:0]             dec_seg_s;
  logic                   dark_s;
  logic [31:0]            readdata_s;
  logic                   unused_wdata_s;

  assign wr_s           = bus.chipselect & ~bus.write_n;
  assign refresh_tc_s   = (refresh_cnt_r == REFRESH_LAST);
  assign unused_wdata_s = ^{bus.writedata[31:16], 1'b0};

  // Register file: VALUE and CTRL; STATUS and address 3 ignore writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_r <= 16'h0000;
      ctrl_r  <= '0;
    end else if (wr_s) begin
      case (bus.address)
        ADDR_VALUE: value_r <= bus.writedata[15:0];
        ADDR_CTRL:  ctrl_r  <= bus.writedata[CTRL_WIDTH-1:0];
        default:    ;
      endcase
    end
  end

  // Digit scan: refresh prescaler advances the digit index 0..3 on wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= 2'd0;
    end else if (refresh_tc_s) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= digit_idx_r + 2'd1;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + REFRESH_W'(1);
    end
  end

  // Blink phase generator, free-running regardless of CTRL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BLINK_W'(1);
    end
  end

  // Source arbitration: a hw_req opens (or extends) a HOLD_CYCLES override window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_r     <= SRC_SW;
      hold_r    <= '0;
      latched_r <= 16'h0000;
    end else begin
      case (src_r)
        SRC_SW: begin
          if (hw_req) begin
            src_r     <= SRC_HW;
            hold_r    <= HOLD_LOAD;
            latched_r <= hw_value;
          end
        end
        SRC_HW: begin
          if (hw_req) begin
            hold_r    <= HOLD_LOAD;
            latched_r <= hw_value;
          end else if (hold_r == '0) begin
            src_r     <= SRC_SW;
          end else begin
            hold_r    <= hold_r - HOLD_W'(1);
          end
        end
        default: begin
          src_r <= SRC_SW;
        end
      endcase
    end
  end

  // Pick the nibble of the currently displayed source for the active digit.
  always_comb begin
    if (src_r == SRC_HW) begin
      shown_s = latched_r;
    end else begin
      shown_s = value_r;
    end
    nibble_s = nibble_sel(shown_s, digit_idx_r);
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_s),
    .seg_n  (dec_seg_s)
  );

  // Darkness: disabled, ghosting guard on the last prescaler count (the
  // registered outputs then go dark for the cycle the index changes),
  // blink off-phase, or a blanked digit.
  always_comb begin
    if (!ctrl_r[CTRL_ENABLE_BIT] || refresh_tc_s) begin
      dark_s = 1'b1;
    end else if (ctrl_r[CTRL_BLINK_BIT] && blink_phase_r) begin
      dark_s = 1'b1;
    end else begin
      dark_s = ctrl_r[CTRL_BLANK_LSB + 32'(digit_idx_r)];
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
      dig_en_n <= 4'hF;
    end else if (dark_s) begin
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
      dig_en_n <= 4'hF;
    end else begin
      seg_n    <= dec_seg_s;
      dp_n     <= ~ctrl_r[CTRL_DP_LSB + 32'(digit_idx_r)];
      dig_en_n <= ~(4'b0001 << digit_idx_r);
    end
  end

  // Zero-wait-state read mux, decoded from address alone.
  always_comb begin
    case (bus.address)
      ADDR_VALUE:  readdata_s = {16'h0000, value_r};
      ADDR_CTRL:   readdata_s = {{(32-CTRL_WIDTH){1'b0}}, ctrl_r};
      ADDR_STATUS: readdata_s = {28'h0000000, digit_idx_r, 1'b0, (src_r == SRC_HW)};
      default:     readdata_s = 32'h00000000;
    endcase
  end

  assign bus.readdata = readdata_s;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
module tb_hex_display_scan_ctrl;

  localparam int R = 4;
  localparam int B = 64;
  localparam int H = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hw_req = 1'b0;
  logic [15:0] hw_value = 16'h0000;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  dig_en_n;

  hex_display_scan_ctrl_if bus ();

  hex_display_scan_ctrl #(.REFRESH_DIV(R), .BLINK_DIV(B), .HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .hw_req   (hw_req),
    .hw_value (hw_value),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .dig_en_n (dig_en_n)
  );

  always #5 clk = ~clk;

  // independent segment table, {g,f,e,d,c,b,a} active-low
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int tests = 0;
  int fails = 0;

  // behavioural model: edges since reset, registers, time of last hw_req
  int          k;
  logic [15:0] m_value;
  logic [11:0] m_ctrl;
  int          last_req;
  logic [15:0] m_latched;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_dig;

  function automatic void model_reset();
    k = 0; m_value = 16'h0; m_ctrl = 12'h0; last_req = -1000000; m_latched = 16'h0;
    exp_seg = 7'h7F; exp_dp = 1'b1; exp_dig = 4'hF;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic active;
    int   idx;
    active = (k - last_req) < H;
    idx = (k / R) % 4;
    case (a)
      2'd0: return {16'h0, m_value};
      2'd1: return {20'h0, m_ctrl};
      2'd2: return {28'h0, idx[1:0], 1'b0, active};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    int d;
    logic guard, phase, active, dark;
    logic [15:0] src;
    @(posedge clk);
    d = (k / R) % 4;
    guard = (k % R) == R - 1;
    phase = ((k / B) % 2) == 1;
    active = (k - last_req) < H;
    src = active ? m_latched : m_value;
    dark = !m_ctrl[0] || guard || (m_ctrl[1] && phase) || m_ctrl[4 + d];
    if (dark) begin
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_dig = 4'hF;
    end else begin
      exp_seg = seg_tab[src[4*d +: 4]];
      exp_dp  = ~m_ctrl[8 + d];
      exp_dig = ~(4'b0001 << d);
    end
    k++;
    if (bus.chipselect && !bus.write_n) begin
      if (bus.address == 2'd0) m_value = bus.writedata[15:0];
      else if (bus.address == 2'd1) m_ctrl = bus.writedata[11:0];
    end
    if (hw_req) begin
      last_req = k;
      m_latched = hw_value;
    end
    @(negedge clk);
    check("dig_en_n", {28'h0, dig_en_n}, {28'h0, exp_dig});
    check("seg_n", {25'h0, seg_n}, {25'h0, exp_seg});
    check("dp_n", {31'h0, dp_n}, {31'h0, exp_dp});
    check("readdata", bus.readdata, exp_read(bus.address));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bus.address = 2'($urandom_range(0, 3));
      tick();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = $urandom;
  endtask

  task automatic pulse_hw(input logic [15:0] v);
    hw_req = 1'b1; hw_value = v;
    bus.address = 2'd2;
    tick();
    hw_req = 1'b0; hw_value = 16'($urandom);
  endtask

  task automatic reset_check(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_dig"}, {28'h0, dig_en_n}, 32'hF);
    check({tag, "_seg"}, {25'h0, seg_n}, 32'h7F);
    check({tag, "_dp"}, {31'h0, dp_n}, 32'h1);
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1 check({tag, "_read"}, bus.readdata, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_check("por");
    run(6);

    // basic scan of 1234
    bus_write(2'd1, 32'h0000_0001);
    bus_write(2'd0, 32'hABCD_1234);
    run(40);

    // decimal point on digit 0, then blank digit 1
    bus_write(2'd1, 32'h0000_0101);
    run(24);
    bus_write(2'd1, 32'h0000_0021);
    run(24);
    bus_write(2'd1, 32'h0000_0001);

    // override window, re-pulse at cycle 10, value write during override
    pulse_hw(16'hBEEF);
    run(4);
    bus_write(2'd0, 32'h0000_5A5A);
    run(4);
    pulse_hw(16'hC0DE);
    run(35);

    // blink
    bus_write(2'd1, 32'h0000_0003);
    run(260);

    // writes to read-only / unused addresses
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus.address = 2'd3;
    tick();
    bus_write(2'd1, 32'h0000_0001);

    // randomized traffic, including same-cycle write + hw_req
    for (int i = 0; i < 1500; i++) begin
      bus.address = 2'($urandom_range(0, 3));
      bus.writedata = $urandom;
      if (bus.address == 2'd1 && $urandom_range(0, 3) != 0) bus.writedata[0] = 1'b1;
      bus.chipselect = ($urandom_range(0, 7) == 0);
      bus.write_n = ($urandom_range(0, 1) == 0);
      hw_req = ($urandom_range(0, 39) == 0);
      hw_value = 16'($urandom);
      tick();
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1; hw_req = 1'b0;

    // reset mid-override and mid-scan
    bus_write(2'd1, 32'h0000_0101);
    pulse_hw(16'h9876);
    run(5);
    reset_check("mid_reset");
    run(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
